uart_rx_frame_ctrl: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 30 +++
 rtl/uart_frame_timer.sv | 28 ++
 rtl/uart_rx_frame_ctrl.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame sequencer: state encoding, sync default,
// checksum width and the bit positions of the error pulse vector.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHK,
        HOLD
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         CHK_W         = 8;

    localparam int ERR_PARITY  = 0;
    localparam int ERR_LEN     = 1;
    localparam int ERR_CHK     = 2;
    localparam int ERR_TIMEOUT = 3;
    localparam int ERR_OVERRUN = 4;
    localparam int ERR_NUM     = 5;

    // Frame is good when the running sum plus the trailing checksum byte wraps to zero.
    function automatic logic chk_ok(input logic [CHK_W-1:0] sum, input logic [7:0] data);
        logic [CHK_W-1:0] total;
        total = sum + data;
        return total == '0;
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: expire is combinational, one clk before the count reaches TIMEOUT_CYC-1.
// No backpressure; clr (a byte arrived) always wins over expiry.
module uart_frame_timer #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || clr) begin
            cnt <= '0;
        end else if (cnt != TIMEOUT_CYC - 16'd1) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Fires on the edge where the count steps onto TIMEOUT_CYC-1, so the registered error lines up with it.
    assign expire = en && !clr && (cnt == TIMEOUT_CYC - 16'd2);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Sync/length/checksum frame assembler behind the UART byte receiver; frame_valid rises 1 clk after the CHK strobe.
// Frame held until frame_valid&frame_ready; bytes arriving while held are dropped with err_overrun. Option: UART_FRAME_STATS_EN.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int          MAX_LEN     = 4,
    parameter logic [15:0] TIMEOUT_CYC = 16'd20000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 rx_perr,
    input  logic                 frame_ready,
    output logic                 frame_valid,
    output logic [2:0]           frame_len,
    output logic [8*MAX_LEN-1:0] frame_data,
    output logic                 err_parity,
    output logic                 err_len,
    output logic                 err_chk,
    output logic                 err_timeout,
    output logic                 err_overrun
`ifdef UART_FRAME_STATS_EN
    ,
    output logic [7:0]           good_cnt,
    output logic [7:0]           bad_cnt
`endif
);

    state_t             state;
    logic [CHK_W-1:0]   sum;
    logic [2:0]         len_q;
    logic [2:0]         idx;
    logic [ERR_NUM-1:0] err_q;
    logic               active;
    logic               sync_hit;
    logic               expire;

    assign active   = (state == LEN) || (state == PAYLOAD) || (state == CHK);
    assign sync_hit = rx_valid && !rx_perr && (rx_data == SYNC_BYTE);

    uart_frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (rx_valid),
        .en     (active),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sum         <= '0;
            len_q       <= '0;
            idx         <= '0;
            err_q       <= '0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            frame_data  <= '0;
        end else begin
            err_q <= '0;
            case (state)
                IDLE: begin
                    if (sync_hit) begin
                        state <= LEN;
                    end
                end

                LEN: begin
                    if (rx_valid) begin
                        if (rx_perr) begin
                            err_q[ERR_PARITY] <= 1'b1;
                            state             <= IDLE;
                        end else if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                            err_q[ERR_LEN] <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            len_q      <= rx_data[2:0];
                            sum        <= rx_data;
                            idx        <= '0;
                            frame_data <= '0;
                            state      <= PAYLOAD;
                        end
                    end else if (expire) begin
                        err_q[ERR_TIMEOUT] <= 1'b1;
                        state              <= IDLE;
                    end
                end

                PAYLOAD: begin
                    if (rx_valid) begin
                        if (rx_perr) begin
                            err_q[ERR_PARITY] <= 1'b1;
                            state             <= IDLE;
                        end else begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                if (idx == 3'(i)) begin
                                    frame_data[i*8 +: 8] <= rx_data;
                                end
                            end
                            sum <= sum + rx_data;
                            idx <= idx + 3'd1;
                            if (idx == len_q - 3'd1) begin
                                state <= CHK;
                            end
                        end
                    end else if (expire) begin
                        err_q[ERR_TIMEOUT] <= 1'b1;
                        state              <= IDLE;
                    end
                end

                CHK: begin
                    if (rx_valid) begin
                        if (rx_perr) begin
                            err_q[ERR_PARITY] <= 1'b1;
                            state             <= IDLE;
                        end else if (chk_ok(sum, rx_data)) begin
                            frame_valid <= 1'b1;
                            frame_len   <= len_q;
                            state       <= HOLD;
                        end else begin
                            err_q[ERR_CHK] <= 1'b1;
                            state          <= IDLE;
                        end
                    end else if (expire) begin
                        err_q[ERR_TIMEOUT] <= 1'b1;
                        state              <= IDLE;
                    end
                end

                HOLD: begin
                    // A byte landing on the handshake cycle is treated as the first IDLE byte.
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        state       <= sync_hit ? LEN : IDLE;
                    end else if (rx_valid) begin
                        err_q[ERR_OVERRUN] <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign err_parity  = err_q[ERR_PARITY];
    assign err_len     = err_q[ERR_LEN];
    assign err_chk     = err_q[ERR_CHK];
    assign err_timeout = err_q[ERR_TIMEOUT];
    assign err_overrun = err_q[ERR_OVERRUN];

`ifdef UART_FRAME_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            if (frame_valid && frame_ready && good_cnt != 8'hFF) begin
                good_cnt <= good_cnt + 8'd1;
            end
            if ((|err_q) && bad_cnt != 8'hFF) begin
                bad_cnt <= bad_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: packet-level reference model feeds expected-event queues,
// a negedge monitor pops and compares every error pulse and frame handshake.
module tb_uart_rx_frame_ctrl;

    localparam int         MAXL = 4;
    localparam int         TO   = 20000;
    localparam logic [7:0] SYNC = 8'hA5;

    localparam int EV_NONE  = -1;
    localparam int EV_PAR   = 0;
    localparam int EV_LEN   = 1;
    localparam int EV_CHK   = 2;
    localparam int EV_TO    = 3;
    localparam int EV_OVR   = 4;
    localparam int EV_FRAME = 5;

    typedef struct {
        int          kind;
        int          cyc;
        logic [2:0]  len;
        logic [31:0] data;
    } ev_t;

    ev_t err_q[$];
    ev_t frm_q[$];

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_perr;
    logic        frame_ready;
    logic        frame_valid;
    logic [2:0]  frame_len;
    logic [31:0] frame_data;
    logic        err_parity;
    logic        err_len;
    logic        err_chk;
    logic        err_timeout;
    logic        err_overrun;
`ifdef UART_FRAME_STATS_EN
    logic [7:0]  good_cnt;
    logic [7:0]  bad_cnt;
`endif

    logic rand_rdy;
    logic rdy_d;
    logic rdy_r;
    assign frame_ready = rand_rdy ? rdy_r : rdy_d;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int obs_err   = 0;
    int exp_good  = 0;
    int exp_bad   = 0;
    bit hs_prev   = 1'b0;
    bit fv_prev   = 1'b0;

    uart_rx_frame_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_perr     (rx_perr),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .frame_data  (frame_data),
        .err_parity  (err_parity),
        .err_len     (err_len),
        .err_chk     (err_chk),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
`ifdef UART_FRAME_STATS_EN
        ,
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rdy_r = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rdy_r = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at cyc %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ev_idx(input logic [4:0] v);
        for (int i = 0; i < 5; i++) if (v[i]) return i;
        return EV_NONE;
    endfunction

    // Reference model: parse one byte list that starts in the hunt state and report the
    // first decisive outcome and the index of the byte that causes it.
    function automatic void predict(input logic [7:0] b[$], input bit p[$], output int kind,
                                    output int at, output logic [2:0] len, output logic [31:0] data);
        int i;
        int n;
        int sum;
        kind = EV_NONE; at = -1; len = '0; data = '0;
        i = 0;
        while (i < b.size() && (p[i] || b[i] != SYNC)) i++;
        i++;
        if (i >= b.size()) return;
        if (p[i]) begin kind = EV_PAR; at = i; return; end
        if (b[i] == 0 || int'(b[i]) > MAXL) begin kind = EV_LEN; at = i; return; end
        n   = int'(b[i]);
        sum = n;
        for (int k = 0; k < n; k++) begin
            i++;
            if (i >= b.size()) return;
            if (p[i]) begin kind = EV_PAR; at = i; return; end
            data[8*k +: 8] = b[i];
            sum += int'(b[i]);
        end
        i++;
        if (i >= b.size()) return;
        if (p[i]) begin kind = EV_PAR; at = i; return; end
        sum += int'(b[i]);
        at   = i;
        len  = 3'(n);
        kind = ((sum % 256) == 0) ? EV_FRAME : EV_CHK;
        if (kind != EV_FRAME) data = '0;
    endfunction

    task automatic push_ev(input int kind, input int c, input logic [2:0] len, input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.cyc = c; e.len = len; e.data = data;
        if (kind == EV_FRAME) begin
            frm_q.push_back(e);
            exp_good++;
        end else begin
            err_q.push_back(e);
            exp_bad++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pe, output int s);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_perr  = pe;
        @(posedge clk);
        #1;
        s        = cyc;
        rx_valid = 1'b0;
        rx_perr  = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((err_q.size() != 0 || frm_q.size() != 0) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (err_q.size() != 0 || frm_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d events still pending at cyc %0d, required 0",
                     err_q.size() + frm_q.size(), cyc);
            err_q.delete();
            frm_q.delete();
        end
    endtask

    task automatic run_list(input logic [7:0] b[$], input bit p[$], input int gap_max, input bit drain_en);
        int          kind;
        int          at;
        int          n;
        int          s;
        logic [2:0]  len;
        logic [31:0] data;
        predict(b, p, kind, at, len, data);
        n = (at < 0) ? b.size() : at + 1;
        for (int i = 0; i < n; i++) begin
            send_byte(b[i], p[i], s);
            if (i == at) push_ev(kind, s, len, data);
            if (i != n - 1) idle($urandom_range(0, gap_max));
        end
        if (drain_en) drain(300);
    endtask

    task automatic rand_txn();
        logic [7:0] b[$];
        bit         p[$];
        logic [7:0] g;
        int         k;
        int         n;
        int         sum;
        logic [7:0] c;
        k = $urandom_range(0, 4);
        if (k == 4) begin
            repeat ($urandom_range(1, 3)) begin
                g = 8'($urandom);
                b.push_back(g);
                p.push_back((g == SYNC) ? 1'b1 : 1'($urandom_range(0, 1)));
            end
        end
        b.push_back(SYNC); p.push_back(1'b0);
        if (k == 2) begin
            b.push_back(($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
            p.push_back(1'b0);
        end else begin
            n = $urandom_range(1, MAXL);
            b.push_back(8'(n)); p.push_back(1'b0);
            sum = n;
            for (int i = 0; i < n; i++) begin
                g = 8'($urandom);
                sum += int'(g);
                b.push_back(g); p.push_back(1'b0);
            end
            c = 8'((256 - (sum % 256)) % 256);
            if (k == 1) c = c + 8'($urandom_range(1, 255));
            b.push_back(c); p.push_back(1'b0);
            if (k == 3) p[$urandom_range(1, b.size() - 1)] = 1'b1;
        end
        run_list(b, p, 3, 1'b1);
    endtask

    // Monitor: every error pulse and every frame handshake is matched against the scoreboard.
    initial begin
        logic [4:0] ev;
        int         nset;
        ev_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hs_prev = 1'b0;
                fv_prev = 1'b0;
            end else begin
                ev   = {err_overrun, err_timeout, err_chk, err_len, err_parity};
                nset = $countones(ev);
                if (nset > 1) begin
                    checks++; errors++;
                    $display("FAIL one_err: %0d pulses at cyc %0d, required 1", nset, cyc);
                end
                if (nset != 0) begin
                    obs_err++;
                    if (err_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_err: got kind %0d at cyc %0d, required none", ev_idx(ev), cyc);
                    end else begin
                        e = err_q.pop_front();
                        chk("err_kind", ev_idx(ev), e.kind);
                        chk("err_cyc", cyc, e.cyc);
                    end
                end
                if (hs_prev) chk("fv_drop", frame_valid, 0);
                if (frame_valid && !fv_prev) begin
                    if (frm_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_frame: got len %0d data 0x%0h, required none", frame_len, frame_data);
                    end else begin
                        chk("fv_lat", cyc, frm_q[0].cyc);
                        chk("rise_len", frame_len, frm_q[0].len);
                        chk("rise_data", frame_data, frm_q[0].data);
                    end
                end
                if (frame_valid && frame_ready && frm_q.size() != 0) begin
                    e = frm_q.pop_front();
                    chk("hs_len", frame_len, e.len);
                    chk("hs_data", frame_data, e.data);
                end
                hs_prev = frame_valid && frame_ready;
                fv_prev = frame_valid;
            end
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_fv"}, frame_valid, 0);
        chk({tag, "_len"}, frame_len, 0);
        chk({tag, "_data"}, frame_data, 0);
        chk({tag, "_err"}, {err_parity, err_len, err_chk, err_timeout, err_overrun}, 0);
`ifdef UART_FRAME_STATS_EN
        chk({tag, "_cnt"}, {good_cnt, bad_cnt}, 0);
`endif
    endtask

    initial begin
        logic [7:0] b[$];
        bit         p[$];
        int         s;
        int         obs0;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_perr = 1'b0;
        rand_rdy = 1'b0; rdy_d = 1'b1;
        #12;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        b = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'hCB}; p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_list(b, p, 2, 1'b1);

        b = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'hCC}; p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_list(b, p, 2, 1'b1);
        b = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7}; p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_list(b, p, 1, 1'b1);

        b = '{8'hA5, 8'h05}; p = '{1'b0, 1'b0};
        run_list(b, p, 1, 1'b1);
        b = '{8'hA5, 8'h00}; p = '{1'b0, 1'b0};
        run_list(b, p, 1, 1'b1);
        obs0 = obs_err;
        b = '{8'h3C, 8'h7E}; p = '{1'b0, 1'b0};
        run_list(b, p, 1, 1'b1);
        idle(5);
        chk("garbage_no_err", obs_err, obs0);

        b = '{8'hA5, 8'h02, 8'h11}; p = '{1'b0, 1'b0, 1'b1};
        run_list(b, p, 1, 1'b1);
        send_byte(8'hA5, 1'b0, s);
        send_byte(8'h02, 1'b0, s);
        send_byte(8'h11, 1'b0, s);
        push_ev(EV_TO, s + TO - 1, 3'd0, 32'h0);
        drain(TO + 50);

        rdy_d = 1'b0;
        b = '{8'hA5, 8'h01, 8'h40, 8'hBF}; p = '{1'b0, 1'b0, 1'b0, 1'b0};
        run_list(b, p, 1, 1'b0);
        idle(3);
        send_byte(8'h55, 1'b0, s);
        push_ev(EV_OVR, s, 3'd0, 32'h0);
        idle(2);
        rdy_d = 1'b1;
        send_byte(8'hA5, 1'b0, s);
        send_byte(8'h01, 1'b0, s);
        send_byte(8'h33, 1'b0, s);
        send_byte(8'hCC, 1'b0, s);
        push_ev(EV_FRAME, s, 3'd1, 32'h0000_0033);
        drain(100);

        rand_rdy = 1'b1;
        repeat (80) rand_txn();
        rand_rdy = 1'b0;
        rdy_d    = 1'b1;
        idle(2);
`ifdef UART_FRAME_STATS_EN
        chk("good_cnt_run", good_cnt, (exp_good > 255) ? 255 : exp_good);
        chk("bad_cnt_run", bad_cnt, (exp_bad > 255) ? 255 : exp_bad);
`endif

        b = '{8'hA5, 8'h03, 8'h11}; p = '{1'b0, 1'b0, 1'b0};
        run_list(b, p, 1, 1'b0);
        rst_n = 1'b0;
        #2;
        check_quiet("midrst");
        @(negedge clk);
        rst_n    = 1'b1;
        exp_good = 0;
        exp_bad  = 0;
        idle(2);
        b = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'hCB}; p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_list(b, p, 2, 1'b1);
        idle(2);
`ifdef UART_FRAME_STATS_EN
        chk("good_cnt_rst", good_cnt, 1);
        chk("bad_cnt_rst", bad_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
